fb_arbiter: RTL and testbench

//   Sequencer/arbiter for the single-port 256x8 framebuffer RAM (sync write, 1-cycle registered read).

---
 rtl/fb_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_fb_arbiter.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fb_arbiter.sv
// fb_arbiter: shares a single-port framebuffer RAM between a CPU load/store port,
// a scan-out engine that streams all addresses in order, and an optional bulk-clear
// engine. The clear engine is built only when FB_CLEAR_EN is defined; otherwise the
// clear ports are inert and the arbiter is a scan/cpu round-robin.
module fb_arbiter #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              scan_start,
    output logic              scan_busy,
    output logic              pix_valid,
    output logic [DATA_W-1:0] pix_data,
    output logic [ADDR_W-1:0] pix_idx,
    output logic              scan_done,
    input  logic              clr_start,
    input  logic [DATA_W-1:0] clr_value,
    output logic              clr_busy,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_din,
    input  logic [DATA_W-1:0] ram_dout
);

    localparam int unsigned       DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {
        SCAN_IDLE = 1'b0,
        SCAN_RUN  = 1'b1
    } scan_state_t;

    scan_state_t       scan_state;
    scan_state_t       scan_state_nxt;
    logic [ADDR_W-1:0] scan_cnt;
    logic [ADDR_W-1:0] scan_cnt_nxt;

    logic              clr_act;
    logic [ADDR_W-1:0] clr_addr;
    logic [DATA_W-1:0] clr_data;

    logic              scan_req;
    logic              cpu_want;
    logic              scan_gnt;
    logic              rr_ptr;     // 0: cpu side wins next contest, 1: scan side

`ifdef FB_CLEAR_EN
    typedef enum logic {
        CLR_IDLE = 1'b0,
        CLR_RUN  = 1'b1
    } clr_state_t;

    clr_state_t        clr_state;
    clr_state_t        clr_state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [ADDR_W-1:0] clr_cnt_nxt;
    logic [DATA_W-1:0] clr_val;
    logic [DATA_W-1:0] clr_val_nxt;

    // Clear engine state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clr_state <= CLR_IDLE;
            clr_cnt   <= '0;
            clr_val   <= '0;
        end else begin
            clr_state <= clr_state_nxt;
            clr_cnt   <= clr_cnt_nxt;
            clr_val   <= clr_val_nxt;
        end
    end

    // Clear engine next state: one write per cycle, never stalled
    always_comb begin
        clr_state_nxt = clr_state;
        clr_cnt_nxt   = clr_cnt;
        clr_val_nxt   = clr_val;
        case (clr_state)
            CLR_IDLE: begin
                if (clr_start) begin
                    clr_state_nxt = CLR_RUN;
                    clr_cnt_nxt   = '0;
                    clr_val_nxt   = clr_value;
                end
            end
            CLR_RUN: begin
                clr_cnt_nxt = clr_cnt + 1'b1;
                if (clr_cnt == LAST_ADDR) begin
                    clr_state_nxt = CLR_IDLE;
                end
            end
            default: clr_state_nxt = CLR_IDLE;
        endcase
    end

    assign clr_act  = (clr_state == CLR_RUN);
    assign clr_addr = clr_cnt;
    assign clr_data = clr_val;
    assign clr_busy = clr_act;
`else
    logic unused_clr;

    assign unused_clr = ^{clr_start, clr_value};
    assign clr_act    = 1'b0;
    assign clr_addr   = '0;
    assign clr_data   = '0;
    assign clr_busy   = 1'b0;
`endif

    // Scan engine state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_state <= SCAN_IDLE;
            scan_cnt   <= '0;
        end else begin
            scan_state <= scan_state_nxt;
            scan_cnt   <= scan_cnt_nxt;
        end
    end

    // Scan engine next state: address advances only on a granted read
    always_comb begin
        scan_state_nxt = scan_state;
        scan_cnt_nxt   = scan_cnt;
        case (scan_state)
            SCAN_IDLE: begin
                if (scan_start) begin
                    scan_state_nxt = SCAN_RUN;
                    scan_cnt_nxt   = '0;
                end
            end
            SCAN_RUN: begin
                if (scan_gnt) begin
                    scan_cnt_nxt = scan_cnt + 1'b1;
                    if (scan_cnt == LAST_ADDR) begin
                        scan_state_nxt = SCAN_IDLE;
                    end
                end
            end
            default: scan_state_nxt = SCAN_IDLE;
        endcase
    end

    assign scan_busy = (scan_state == SCAN_RUN);

    // Arbitration: clear preempts everything, scan and cpu share by round-robin
    always_comb begin
        scan_req = scan_busy && !clr_act;
        cpu_want = cpu_req && !clr_act && rst_n;
        scan_gnt = scan_req && (!cpu_want || rr_ptr);
        cpu_gnt  = cpu_want && (!scan_req || !rr_ptr);
    end

    // Round-robin pointer flips only after a contested grant
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr <= 1'b0;
        end else if (scan_req && cpu_want) begin
            rr_ptr <= ~rr_ptr;
        end
    end

    // RAM port mux; idle cycles drive all zeros
    always_comb begin
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (clr_act) begin
            ram_we   = 1'b1;
            ram_addr = clr_addr;
            ram_din  = clr_data;
        end else if (scan_gnt) begin
            ram_addr = scan_cnt;
        end else if (cpu_gnt) begin
            ram_we   = cpu_we;
            ram_addr = cpu_addr;
            ram_din  = cpu_we ? cpu_wdata : '0;
        end
    end

    // Read tag pipeline: who issued the read and from where, aligned with ram_dout
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cpu_rvalid <= 1'b0;
            pix_valid  <= 1'b0;
            pix_idx    <= '0;
            scan_done  <= 1'b0;
        end else begin
            cpu_rvalid <= cpu_gnt && !cpu_we;
            pix_valid  <= scan_gnt;
            pix_idx    <= scan_gnt ? scan_cnt : '0;
            scan_done  <= scan_gnt && (scan_cnt == LAST_ADDR);
        end
    end

    assign cpu_rdata = cpu_rvalid ? ram_dout : '0;
    assign pix_data  = pix_valid  ? ram_dout : '0;

endmodule

// File: tb/tb_fb_arbiter.sv
// Scoreboard bench for fb_arbiter with a behavioural 256x8 sync RAM.
module tb_fb_arbiter;

    localparam int unsigned AW    = 8;
    localparam int unsigned DW    = 8;
    localparam int unsigned DEPTH = 256;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_gnt, cpu_rvalid;
    logic [DW-1:0] cpu_rdata;
    logic          scan_start, scan_busy, pix_valid, scan_done;
    logic [DW-1:0] pix_data;
    logic [AW-1:0] pix_idx;
    logic          clr_start, clr_busy;
    logic [DW-1:0] clr_value;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    fb_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
        .scan_start(scan_start), .scan_busy(scan_busy), .pix_valid(pix_valid),
        .pix_data(pix_data), .pix_idx(pix_idx), .scan_done(scan_done),
        .clr_start(clr_start), .clr_value(clr_value), .clr_busy(clr_busy),
        .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem   [DEPTH];
    logic [DW-1:0] model [DEPTH];

    // Sync-write, registered-read RAM
    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_din;
        ram_dout <= mem[ram_addr];
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [DW-1:0] data; int cyc; } cpu_exp_t;
    typedef struct { logic [AW-1:0] idx; logic [DW-1:0] data; logic done; int cyc; } pix_exp_t;

    cpu_exp_t cpu_q [$];
    pix_exp_t pix_q [$];

    int vectors = 0;
    int miscompares = 0;
    logic mon_en = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops expectations whenever the DUT presents read data
    always @(negedge clk) begin
        if (mon_en) begin
            if (cpu_rvalid) begin
                if (cpu_q.size() == 0) begin
                    check("cpu_rvalid_unexpected", 1, 0);
                end else begin
                    cpu_exp_t e;
                    e = cpu_q.pop_front();
                    check("cpu_rdata", int'(cpu_rdata), int'(e.data));
                    if (e.cyc >= 0) check("cpu_rvalid_cycle", cyc, e.cyc);
                end
            end
            if (pix_valid) begin
                if (pix_q.size() == 0) begin
                    check("pix_valid_unexpected", 1, 0);
                end else begin
                    pix_exp_t p;
                    p = pix_q.pop_front();
                    check("pix_idx", int'(pix_idx), int'(p.idx));
                    check("pix_data", int'(pix_data), int'(p.data));
                    check("scan_done", int'(scan_done), int'(p.done));
                    if (p.cyc >= 0) check("pix_cycle", cyc, p.cyc);
                end
            end else if (scan_done) begin
                check("scan_done_stray", 1, 0);
            end
        end
    end

    task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        @(negedge clk);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
        #1;
        check("cpu_gnt_uncontested", int'(cpu_gnt), 1);
        check("ram_addr_cpu", int'(ram_addr), int'(a));
        check("ram_we_cpu", int'(ram_we), int'(we));
        if (we) begin
            check("ram_din_cpu", int'(ram_din), int'(d));
            model[a] = d;
        end else begin
            cpu_q.push_back('{data: model[a], cyc: cyc + 1});
        end
        @(negedge clk);
        cpu_req = 1'b0; cpu_we = 1'b0;
    endtask

    task automatic push_scan(input int base);
        for (int i = 0; i < int'(DEPTH); i++) begin
            pix_q.push_back('{idx: AW'(i), data: model[i], done: (i == int'(DEPTH) - 1),
                              cyc: (base < 0) ? -1 : base + i});
        end
    endtask

    task automatic wait_scan_idle(input string name);
        int n;
        n = 0;
        while (scan_busy && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check(name, int'(scan_busy), 0);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation did not finish, got running expected finished");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        logic [AW-1:0] a;

        rst_n = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        scan_start = 1'b0; clr_start = 1'b0; clr_value = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            mem[i]   = DW'(i) ^ 8'h5A;
            model[i] = DW'(i) ^ 8'h5A;
        end

        // Power-on reset values
        repeat (3) @(negedge clk);
        check("por_scan_busy", int'(scan_busy), 0);
        check("por_clr_busy", int'(clr_busy), 0);
        check("por_cpu_rvalid", int'(cpu_rvalid), 0);
        check("por_pix_valid", int'(pix_valid), 0);
        rst_n = 1'b1;

        // Reset in the middle of a scan with a cpu read pending
        @(negedge clk); scan_start = 1'b1;
        @(negedge clk); scan_start = 1'b0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h00;
        repeat (20) @(negedge clk);
        check("pre_reset_scan_busy", int'(scan_busy), 1);
        rst_n = 1'b0;
        #1;
        check("reset_scan_busy", int'(scan_busy), 0);
        check("reset_pix_valid", int'(pix_valid), 0);
        check("reset_cpu_gnt", int'(cpu_gnt), 0);
        check("reset_ram_we", int'(ram_we), 0);
        @(negedge clk); cpu_req = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); mon_en = 1'b1;

        // Idle RAM port
        #1;
        check("idle_ram_addr", int'(ram_addr), 0);
        check("idle_ram_we", int'(ram_we), 0);
        check("idle_ram_din", int'(ram_din), 0);

        // CPU write then read back, plus boundary address and untouched data
        cpu_access(1'b1, 8'h10, 8'hA5);
        cpu_access(1'b0, 8'h10, 8'h00);
        cpu_access(1'b1, 8'hFF, 8'hC3);
        cpu_access(1'b0, 8'hFF, 8'h00);
        cpu_access(1'b0, 8'h20, 8'h00);
        cpu_access(1'b0, 8'h00, 8'h00);

        // Uncontested scan: 256 back-to-back pixels; a second start mid-scan is ignored
        @(negedge clk); scan_start = 1'b1;
        push_scan(cyc + 2);
        @(negedge clk); scan_start = 1'b0;
        n = 0;
        while (scan_busy && n < 600) begin
            n++;
            scan_start = (n == 100);
            @(negedge clk);
        end
        scan_start = 1'b0;
        check("scan_busy_cycles", n, 256);

        // Scan with cpu requesting every cycle: grants alternate, cpu first
        @(negedge clk); scan_start = 1'b1;
        push_scan(-1);
        @(negedge clk); scan_start = 1'b0;
        n = 0; a = 8'h03;
        while (scan_busy && n < 1200) begin
            cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
            #1;
            check("rr_cpu_gnt", int'(cpu_gnt), ((n % 2) == 0) ? 1 : 0);
            if (cpu_gnt) begin
                cpu_q.push_back('{data: model[a], cyc: cyc + 1});
                a = a + 8'd7;
            end
            n++;
            @(negedge clk);
        end
        cpu_req = 1'b0;
        check("contested_scan_cycles", n, 512);

        // Clear and scan started together
        @(negedge clk);
        clr_start = 1'b1; clr_value = 8'h3C; scan_start = 1'b1;
`ifdef FB_CLEAR_EN
        for (int i = 0; i < int'(DEPTH); i++) model[i] = 8'h3C;
`endif
        push_scan(-1);
        @(negedge clk);
        clr_start = 1'b0; scan_start = 1'b0; clr_value = 8'h00;
`ifdef FB_CLEAR_EN
        n = 0;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h55;
        while (clr_busy && n < 600) begin
            #1;
            check("clr_cpu_stall", int'(cpu_gnt), 0);
            check("clr_no_pixel", int'(pix_valid), 0);
            n++;
            @(negedge clk);
        end
        check("clr_busy_cycles", n, 256);
        #1;
        check("post_clr_cpu_gnt", int'(cpu_gnt), 1);
        if (cpu_gnt) cpu_q.push_back('{data: model[8'h55], cyc: cyc + 1});
        @(negedge clk); cpu_req = 1'b0;
`else
        seen = 0;
        repeat (300) begin
            if (clr_busy) seen++;
            @(negedge clk);
        end
        check("clr_busy_disabled", seen, 0);
`endif
        wait_scan_idle("clr_scan_finish");

        // Drain outstanding expectations
        n = 0;
        while ((cpu_q.size() != 0 || pix_q.size() != 0) && n < 20) begin
            n++;
            @(negedge clk);
        end
        check("cpu_q_drained", cpu_q.size(), 0);
        check("pix_q_drained", pix_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
